lin_interp: RTL

LIN_INTERP -- requirements
Module: lin_interp

---
 rtl/lin_interp.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/lin_interp.sv
// lin_interp: linear-interpolating upsampler, N = 2**LOG2_RATE outputs
// per input sample, fed through a 2-entry skid FIFO.
// Ports:
//   clock, reset        single clock, synchronous active-high reset
//   vin/vin_valid/ready low-rate signed sample input handshake
//   interp_o/valid      registered full-rate interpolated output
//   underrun            one-cycle pulse when input runs dry mid-stream
module lin_interp #(
  parameter int LOG2_RATE = 4,
  parameter int WIDTH     = 20
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] vin,
  input  logic                    vin_valid,
  output logic                    vin_ready,
  output logic signed [WIDTH-1:0] interp_o,
  output logic                    interp_valid,
  output logic                    underrun
);

  localparam int AW = WIDTH + LOG2_RATE + 1;
  localparam int SW = WIDTH + 1;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_PRIME,
    S_RUN,
    S_HOLD
  } state_e;

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       mem_q [2];
  logic                   rd_q, wr_q;
  logic [1:0]             occ_q, occ_d;
  logic                   push, pop, nempty;
  logic [WIDTH-1:0]       head;

  logic signed [WIDTH-1:0] prev_q, prev_d;
  logic signed [WIDTH-1:0] curr_q, curr_d;
  logic signed [SW-1:0]    step_q, step_d;
  logic signed [AW-1:0]    acc_q, acc_d;
  logic [LOG2_RATE-1:0]    phase_q, phase_d;
  logic signed [WIDTH-1:0] out_d;
  logic                    valid_d, und_d;

  // Ready depends on registered occupancy only.
  assign vin_ready = (occ_q < 2'd2);
  assign push      = vin_valid & vin_ready;
  assign nempty    = (occ_q != 2'd0);
  assign head      = mem_q[rd_q];

  always_comb begin
    occ_d = occ_q;
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      occ_q    <= 2'd0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= vin;
        wr_q        <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      occ_q <= occ_d;
    end
  end

  // Segment start value: sample scaled into accumulator units.
  function automatic logic signed [AW-1:0] scale(
    input logic signed [WIDTH-1:0] x
  );
    logic signed [AW-1:0] e;
    e = {{(LOG2_RATE+1){x[WIDTH-1]}}, x};
    return e <<< LOG2_RATE;
  endfunction

  function automatic logic signed [SW-1:0] diff(
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b
  );
    return {a[WIDTH-1], a} - {b[WIDTH-1], b};
  endfunction

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    curr_d  = curr_q;
    step_d  = step_q;
    acc_d   = acc_q;
    phase_d = phase_q;
    out_d   = interp_o;
    valid_d = interp_valid;
    und_d   = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      S_EMPTY: begin
        out_d   = '0;
        valid_d = 1'b0;
        if (nempty) begin
          pop     = 1'b1;
          prev_d  = head;
          state_d = S_PRIME;
        end
      end
      S_PRIME: begin
        out_d   = '0;
        valid_d = 1'b0;
        if (nempty) begin
          pop     = 1'b1;
          curr_d  = head;
          step_d  = diff(head, prev_q);
          acc_d   = scale(prev_q);
          phase_d = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Floor shift: low bits of acc are dropped.
        out_d   = acc_q[WIDTH+LOG2_RATE-1:LOG2_RATE];
        valid_d = 1'b1;
        if (&phase_q) begin
          if (nempty) begin
            pop     = 1'b1;
            prev_d  = curr_q;
            curr_d  = head;
            step_d  = diff(head, curr_q);
            acc_d   = scale(curr_q);
            phase_d = '0;
          end else begin
            und_d   = 1'b1;
            state_d = S_HOLD;
          end
        end else begin
          acc_d   = acc_q + {{LOG2_RATE{step_q[SW-1]}}, step_q};
          phase_d = phase_q + 1'b1;
        end
      end
      S_HOLD: begin
        out_d   = curr_q;
        valid_d = 1'b1;
        if (nempty) begin
          pop     = 1'b1;
          prev_d  = curr_q;
          curr_d  = head;
          step_d  = diff(head, curr_q);
          acc_d   = scale(curr_q);
          phase_d = '0;
          state_d = S_RUN;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_EMPTY;
      prev_q       <= '0;
      curr_q       <= '0;
      step_q       <= '0;
      acc_q        <= '0;
      phase_q      <= '0;
      interp_o     <= '0;
      interp_valid <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      curr_q       <= curr_d;
      step_q       <= step_d;
      acc_q        <= acc_d;
      phase_q      <= phase_d;
      interp_o     <= out_d;
      interp_valid <= valid_d;
      underrun     <= und_d;
    end
  end

endmodule
